// File: rtl/seg_scan_pkg.sv
// Shared types and active-low seven-segment glyph constants for seg_scan_display.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low seven-segment encoder (hex digits 0-F).
module seg7_glyph
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Binary-to-decimal/hex multiplexed seven-segment display driver with double-dabble conversion.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  hex_mode,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int HEX_W = (DATA_W < BCD_W) ? DATA_W : BCD_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                  state_q;
  logic [DATA_W-1:0]       shift_q;
  logic                    hex_q;
  logic [BCD_W-1:0]        bcd_q;
  logic                    convOvf_q;
  logic [CNT_W-1:0]        bitCnt_q;
  logic [BCD_W-1:0]        digits_q;
  logic                    overflow_q;
  logic [REF_W-1:0]        refresh_q;
  logic [SEL_W-1:0]        sel_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;

  logic [BCD_W-1:0]        bcdAdj;
  logic [BCD_W-1:0]        bcd_d;
  logic                    bcdCarry;
  logic [BCD_W-1:0]        hexDigits;
  logic                    hexOvf;
  logic [SEL_W-1:0]        sel_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic [3:0]              digitNibble;
  logic [6:0]              glyphSeg;
  logic                    blankSel;

  // Double-dabble step: correct every BCD digit, then shift the next binary MSB in.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {bcdCarry, bcd_d} = {bcdAdj, shift_q[DATA_W-1]};

  always_comb begin
    hexDigits = '0;
    hexOvf    = 1'b0;
    for (int i = 0; i < HEX_W; i++) begin
      hexDigits[i] = shift_q[i];
    end
    for (int i = BCD_W; i < DATA_W; i++) begin
      if (shift_q[i]) hexOvf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hex_q      <= 1'b0;
      bcd_q      <= '0;
      convOvf_q  <= 1'b0;
      bitCnt_q   <= '0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= value;
            hex_q     <= hex_mode;
            bcd_q     <= '0;
            convOvf_q <= 1'b0;
            bitCnt_q  <= '0;
            state_q   <= hex_mode ? COMMIT : CONV;
          end
        end
        CONV: begin
          bcd_q     <= bcd_d;
          convOvf_q <= convOvf_q | bcdCarry;
          shift_q   <= shift_q << 1;
          bitCnt_q  <= bitCnt_q + 1'b1;
          if (bitCnt_q == CNT_W'(DATA_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          digits_q   <= hex_q ? hexDigits : bcd_q;
          overflow_q <= hex_q ? hexOvf : convOvf_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_d       = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
  assign an_d        = ~(NUM_DIGITS'(1) << sel_d);
  assign digitNibble = digits_q[int'(sel_d)*4 +: 4];

  seg7_glyph u_glyph (
    .nibble_i (digitNibble),
    .seg_o    (glyphSeg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] leadZero;

  // A digit is leading-zero only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic above;
    above    = 1'b1;
    leadZero = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digits_q[4*i +: 4] != 4'd0) above = 1'b0;
      leadZero[i] = above;
    end
  end

  assign blankSel = leadZero[sel_d];
`else
  assign blankSel = 1'b0;
`endif

  assign seg_d = overflow_q ? SEG_DASH : (blankSel ? SEG_BLANK : glyphSeg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      sel_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with a short refresh period.
module tb_seg_scan_display;

  localparam int DATA_W      = 16;
  localparam int NUM_DIGITS  = 4;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GDASH  = 7'b0111111;
  localparam logic [6:0] GBLANK = 7'b1111111;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] LZ = GBLANK;
`else
  localparam logic [6:0] LZ = G0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DATA_W-1:0]     value;
  logic                  load;
  logic                  hex_mode;
  logic                  busy;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;

  int         errors = 0;
  int         checks = 0;
  int         busyLen;
  logic [6:0] scanSeg [4];
  logic [3:0] seen;
  int         orderErr;

  seg_scan_display #(
    .DATA_W      (DATA_W),
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .busy     (busy),
    .overflow (overflow),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] v, input logic hexMode);
    value    = v;
    hex_mode = hexMode;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic captureScan();
    logic [3:0] prevAn;
    int idx;
    seen     = '0;
    orderErr = 0;
    @(negedge clk);
    prevAn = an;
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      @(negedge clk);
      if (an != prevAn) begin
        case (an)
          4'b1110: idx = 0;
          4'b1101: idx = 1;
          4'b1011: idx = 2;
          4'b0111: idx = 3;
          default: idx = -1;
        endcase
        if (idx >= 0) begin
          scanSeg[idx] = seg;
          seen[idx]    = 1'b1;
        end else begin
          orderErr++;
        end
        if (prevAn != 4'b1111 && an != {prevAn[2:0], prevAn[3]}) orderErr++;
        prevAn = an;
      end
    end
  endtask

  task automatic checkScan(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
    captureScan();
    checkOutput({tag, "_seen"}, 32'(seen), 32'hF);
    checkOutput({tag, "_order"}, 32'(orderErr), 32'd0);
    checkOutput({tag, "_d0"}, 32'(scanSeg[0]), 32'(e0));
    checkOutput({tag, "_d1"}, 32'(scanSeg[1]), 32'(e1));
    checkOutput({tag, "_d2"}, 32'(scanSeg[2]), 32'(e2));
    checkOutput({tag, "_d3"}, 32'(scanSeg[3]), 32'(e3));
  endtask

  initial begin
    rst      = 1'b1;
    value    = '0;
    load     = 1'b0;
    hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] decimal 1234");
    applyStimulus(16'd1234, 1'b0);
    waitIdle(busyLen);
    checkOutput("dec1234_busy", 32'(busyLen), 32'd17);
    checkOutput("dec1234_ovf", 32'(overflow), 32'd0);
    checkScan("dec1234", G1, G2, G3, G4);

    $display("[TB] hex BEEF");
    applyStimulus(16'hBEEF, 1'b1);
    waitIdle(busyLen);
    checkOutput("hexBEEF_busy", 32'(busyLen), 32'd1);
    checkOutput("hexBEEF_ovf", 32'(overflow), 32'd0);
    checkScan("hexBEEF", GB, GE, GE, GF);

    $display("[TB] decimal 10000");
    applyStimulus(16'd10000, 1'b0);
    waitIdle(busyLen);
    checkOutput("dec10000_busy", 32'(busyLen), 32'd17);
    checkOutput("dec10000_ovf", 32'(overflow), 32'd1);
    checkScan("dec10000", GDASH, GDASH, GDASH, GDASH);

    $display("[TB] decimal 9999 then back-to-back hex load");
    applyStimulus(16'd9999, 1'b0);
    waitIdle(busyLen);
    checkOutput("dec9999_busy", 32'(busyLen), 32'd17);
    checkOutput("dec9999_ovf", 32'(overflow), 32'd0);
    applyStimulus(16'hAC0D, 1'b1);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitIdle(busyLen);
    checkScan("hexAC0D", GA, GC, G0, GD);

    $display("[TB] load while busy");
    applyStimulus(16'd42, 1'b0);
    @(negedge clk);
    applyStimulus(16'd99, 1'b0);
    waitIdle(busyLen);
    checkOutput("dec42_busy", 32'(busyLen), 32'd15);
    checkOutput("dec42_ovf", 32'(overflow), 32'd0);
    checkScan("dec42", LZ, LZ, G4, G2);

    $display("[TB] reset mid conversion");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(16'd5678, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_an", 32'(an), 32'hF);
    checkOutput("abort_seg", 32'(seg), 32'h7F);
    checkOutput("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    checkScan("abort", LZ, LZ, LZ, G0);

    $display("[TB] small values");
    applyStimulus(16'd7, 1'b0);
    waitIdle(busyLen);
    checkScan("dec7", LZ, LZ, LZ, G7);
    applyStimulus(16'd10000, 1'b0);
    waitIdle(busyLen);
    applyStimulus(16'd0, 1'b0);
    waitIdle(busyLen);
    checkOutput("dec0_ovf", 32'(overflow), 32'd0);
    checkScan("dec0", LZ, LZ, LZ, G0);
    applyStimulus(16'd9, 1'b0);
    waitIdle(busyLen);
    checkScan("dec9", LZ, LZ, LZ, G9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter DATA_W, default 16, width of the binary input value.
REQ-002 Parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1-8).
REQ-003 Parameter REFRESH_DIV, default 65536, clk cycles per digit slot (>= 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 value  in  DATA_W  unsigned binary value to display.
REQ-008 load  in  1  single-cycle strobe; captures value and hex_mode when accepted.
REQ-009 hex_mode  in  1  1 = display hexadecimal, 0 = display decimal.
REQ-010 busy  out  1  high while a capture is being processed; load is ignored while busy.
REQ-011 overflow  out  1  high when the committed value does not fit in NUM_DIGITS digits.
REQ-012 an  out  NUM_DIGITS  active-low one-hot digit enables, bit 0 = rightmost digit.
REQ-013 seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.

Function
REQ-014 FSM states: IDLE, CONV, COMMIT; busy = (state != IDLE).
REQ-015 IDLE: load=1 captures value/hex_mode; next state is CONV if decimal, COMMIT if hex.
REQ-016 CONV: iterative double-dabble (add 3 to each BCD digit >= 5, then shift in the next MSB), one bit per cycle, exactly DATA_W cycles.
REQ-017 The BCD register SHALL be 4*NUM_DIGITS bits; a 1 shifted out of the top digit sets a sticky conversion overflow flag.
REQ-018 Hex: digit i = value[4i+3:4i]; overflow if any value bit at or above 4*NUM_DIGITS is 1.
REQ-019 COMMIT: write the digit register and overflow in one cycle, then return to IDLE.
REQ-020 Latency from load to digit register update: decimal DATA_W+1 cycles, hex 1 cycle; busy is high for exactly that many cycles.
REQ-021 load while busy SHALL be dropped without effect; a load in the cycle busy falls is accepted.
REQ-022 While overflow=1, every digit SHALL show a dash (only segment g lit).
REQ-023 The refresh counter counts 0..REFRESH_DIV-1 and wraps; each wrap advances the digit select, which wraps from NUM_DIGITS-1 to 0.
REQ-024 an and seg are registered, updated on refresh wrap, and always reflect the same digit.
REQ-025 The display SHALL keep showing the previously committed digits while a conversion runs (no partial values).

Reset
REQ-026 rst forces: state IDLE, busy 0, overflow 0, digit register all zero, refresh counter 0, digit select 0, an all ones, seg all ones.
REQ-027 rst during CONV SHALL abort the conversion; nothing is committed.

Configuration
REQ-028 Macro SEG_LZ_BLANK_EN defined: leading zero digits (above the most significant non-zero digit) are blanked (seg all ones); digit 0 is never blanked; no effect while overflow=1.
REQ-029 SEG_LZ_BLANK_EN undefined: every digit, including leading zeros, is displayed.

Structure
REQ-030 Package seg_scan_pkg SHALL hold the FSM state type, the active-low glyph constants for 0-F, and the dash and blank constants.
REQ-031 Sub-module seg7_glyph: combinational nibble to active-low 7-segment encoder, one instance on the selected digit.

Verification
REQ-032 Decimal, value=1234, load -> busy high for 17 cycles; digits 4,3,2,1 scanned on an 1110,1101,1011,0111; overflow 0.
REQ-033 Hex, value=16'hBEEF, load -> busy high for 1 cycle; digits F,E,E,B displayed.
REQ-034 Decimal, value=10000 -> overflow 1; all four digits show dash (seg 0111111).
REQ-035 Load 42, then load 99 two cycles later -> second load ignored; 0042 committed.
REQ-036 Assert rst at cycle 8 of a decimal conversion -> busy 0; an and seg all ones; digits remain 0.
REQ-037 With SEG_LZ_BLANK_EN defined, decimal 7 -> digit 0 shows 7; digits 1-3 blank. Value 0 -> only digit 0 shows 0.
